// File: rtl/my_fsm_security_pkg.sv
// Shared constants for the security FSM: state encoding, arm key code,
// delay length and display refresh divisor.
package my_fsm_security_pkg;

   typedef enum logic [1:0] {
      ST_DISARMED   = 2'd0,
      ST_ARMED      = 2'd1,
      ST_WAIT_DELAY = 2'd2,
      ST_ALARM      = 2'd3
   } state_e;

   localparam logic [1:0] ARM_KEY     = 2'b11;
   localparam int         DELAY_SEC   = 5;
   localparam int         REFRESH_DIV = 1000;
   localparam int         DIGIT_W     = 4;
   localparam int         SEG_W       = 7;

   // Clamps derived widths/periods so tiny CLK_FREQ values still elaborate.
   function automatic int at_least_one(input int v);
      return (v < 1) ? 1 : v;
   endfunction

endpackage

// File: rtl/my_fsm_security_seg7_decoder.sv
// Hex digit to active-high seven-segment pattern {g,f,e,d,c,b,a}.
module seg7_decoder
   import my_fsm_security_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_i,
   output logic [SEG_W-1:0]   seg_o
);

   always_comb begin
      seg_o = '0;
      case (digit_i)
         4'h0: seg_o = 7'h3F;
         4'h1: seg_o = 7'h06;
         4'h2: seg_o = 7'h5B;
         4'h3: seg_o = 7'h4F;
         4'h4: seg_o = 7'h66;
         4'h5: seg_o = 7'h6D;
         4'h6: seg_o = 7'h7D;
         4'h7: seg_o = 7'h07;
         4'h8: seg_o = 7'h7F;
         4'h9: seg_o = 7'h6F;
         4'hA: seg_o = 7'h77;
         4'hB: seg_o = 7'h7C;
         4'hC: seg_o = 7'h39;
         4'hD: seg_o = 7'h5E;
         4'hE: seg_o = 7'h79;
         4'hF: seg_o = 7'h71;
      endcase
   end

endmodule

// File: rtl/my_fsm_security.sv
// Arm/disarm security FSM with a 5 s entry delay and a two-digit
// multiplexed display (left: state code, right: seconds remaining).
module my_fsm_security
   import my_fsm_security_pkg::*;
#(
   parameter int CLK_FREQ = 125_000_000
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [1:0]       KEY,
   input  logic             DOOR,
   input  logic             WINDOW,
   output logic             ALARM,
   output logic [SEG_W-1:0] AN,
   output logic             CA
);

   localparam int DELAY_CYC = DELAY_SEC * CLK_FREQ;
   localparam int CNT_W     = at_least_one($clog2(DELAY_CYC));
   localparam int REF_CYC   = at_least_one(CLK_FREQ / REFRESH_DIV);
   localparam int REF_W     = at_least_one($clog2(REF_CYC));

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [REF_W-1:0]   ref_q, ref_d;
   logic               ca_q, ca_d;
   logic               count_done, tick;
   logic [CNT_W-1:0]   elapsed;
   logic [DIGIT_W-1:0] right_dig, digit;

   assign count_done = (state_q == ST_WAIT_DELAY) && (cnt_q == CNT_W'(DELAY_CYC - 1));
   assign tick       = (ref_q == REF_W'(REF_CYC - 1));

   // Disarm always wins over sensor and timeout transitions.
   always_comb begin
      state_d = state_q;
      if (KEY != ARM_KEY) begin
         state_d = ST_DISARMED;
      end else begin
         case (state_q)
            ST_DISARMED:   state_d = ST_ARMED;
            ST_ARMED:      if (DOOR || WINDOW) state_d = ST_WAIT_DELAY;
            ST_WAIT_DELAY: if (count_done) state_d = ST_ALARM;
            default:       state_d = state_q;
         endcase
      end
   end

   always_comb begin
      cnt_d = '0;
      if ((state_q == ST_WAIT_DELAY) && !count_done) cnt_d = cnt_q + CNT_W'(1);
      ref_d = tick ? '0 : ref_q + REF_W'(1);
      ca_d  = ca_q ^ tick;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= ST_DISARMED;
         cnt_q   <= '0;
         ref_q   <= '0;
         ca_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ref_q   <= ref_d;
         ca_q    <= ca_d;
      end
   end

   assign elapsed   = cnt_q / CNT_W'(CLK_FREQ);
   assign right_dig = (state_q == ST_WAIT_DELAY) ? DIGIT_W'(DELAY_SEC) - DIGIT_W'(elapsed) : '0;
   assign digit     = ca_q ? DIGIT_W'(state_q) : right_dig;

   assign ALARM = (state_q == ST_ALARM);
   assign CA    = ca_q;

   seg7_decoder u_seg7 (
      .digit_i (digit),
      .seg_o   (AN)
   );

endmodule

// File: tb/tb_my_fsm_security.sv
// Bench for my_fsm_security: vector table, corner sequences and random
// stimulus against a cycle-level behavioural model (CLK_FREQ=10/1000/3000).
module tb_my_fsm_security;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic [1:0] key_a, key_b;
   logic       door_a, win_a, door_b, win_b;
   logic       alarm_a, alarm_b, alarm_c, ca_a, ca_b, ca_c;
   logic [6:0] an_a, an_b, an_c;

   my_fsm_security #(.CLK_FREQ(10)) dut_a (
      .CLK(clk), .RST(rst), .KEY(key_a), .DOOR(door_a), .WINDOW(win_a),
      .ALARM(alarm_a), .AN(an_a), .CA(ca_a));

   my_fsm_security #(.CLK_FREQ(1000)) dut_b (
      .CLK(clk), .RST(rst), .KEY(key_b), .DOOR(door_b), .WINDOW(win_b),
      .ALARM(alarm_b), .AN(an_b), .CA(ca_b));

   my_fsm_security #(.CLK_FREQ(3000)) dut_c (
      .CLK(clk), .RST(rst), .KEY(2'b00), .DOOR(1'b0), .WINDOW(1'b0),
      .ALARM(alarm_c), .AN(an_c), .CA(ca_c));

   localparam logic [6:0] SEG [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

   int n_tests = 0;
   int n_fail  = 0;

   // Model of dut_a: state code, cycles spent waiting, display phase.
   int m_st, m_w;
   bit m_ca;

   typedef struct {
      logic [1:0] key;
      logic       door;
      logic       win;
      int         exp_st;
      bit         exp_alarm;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_w = 0; m_ca = 1'b0;
   endtask

   task automatic model_step();
      m_ca = ~m_ca;
      if (key_a != 2'b11) begin
         m_st = 0; m_w = 0;
      end else begin
         case (m_st)
            0: m_st = 1;
            1: if (door_a || win_a) begin m_st = 2; m_w = 0; end
            2: if (m_w == 49) m_st = 3; else m_w++;
            default: ;
         endcase
      end
   endtask

   task automatic check_model();
      int d;
      d = m_ca ? m_st : ((m_st == 2) ? 5 - m_w / 10 : 0);
      chk("A alarm", alarm_a, int'(m_st == 3));
      chk("A ca", ca_a, int'(m_ca));
      chk("A an", an_a, int'(SEG[d]));
   endtask

   task automatic cyc_a(input logic [1:0] k, input logic d, input logic w);
      key_a = k; door_a = d; win_a = w;
      @(posedge clk);
      model_step();
      #1;
      check_model();
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      key_a = 2'b00; door_a = 1'b0; win_a = 1'b0;
      key_b = 2'b00; door_b = 1'b0; win_b = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("reset alarm", alarm_a | alarm_b | alarm_c, 0);
      chk("reset ca", ca_a | ca_b | ca_c, 0);
      chk("reset an A", an_a, 7'b0111111);
      chk("reset an B", an_b, 7'b0111111);
      rst = 1'b1;
      model_reset();
   endtask

   // Arm, open the door, then count edges until the siren comes up.
   task automatic alarm_entry();
      int cnt;
      cyc_a(2'b11, 1'b0, 1'b0);
      cyc_a(2'b11, 1'b1, 1'b0);
      cnt = 0;
      while (!alarm_a && cnt < 100) begin
         cyc_a(2'b11, 1'b1, 1'b0);
         cnt++;
      end
      chk("alarm latency", cnt, 50);
   endtask

   vec_t vecs[$];

   initial begin
      int prev, last, first, nt;
      rst = 1'b0;
      key_a = 2'b00; door_a = 1'b0; win_a = 1'b0;
      key_b = 2'b00; door_b = 1'b0; win_b = 1'b0;
      #2;
      chk("pre-clock alarm", alarm_a, 0);
      chk("pre-clock an", an_a, 7'b0111111);
      chk("pre-clock ca", ca_a, 0);
      do_reset();

      // Arm/disarm, then a short aborted entry delay.
      vecs.push_back('{2'b11, 1'b0, 1'b0, 1, 1'b0});
      for (int i = 0; i < 9; i++) vecs.push_back('{2'b11, 1'b0, 1'b0, 1, 1'b0});
      vecs.push_back('{2'b00, 1'b0, 1'b0, 0, 1'b0});
      vecs.push_back('{2'b01, 1'b0, 1'b1, 0, 1'b0});
      vecs.push_back('{2'b11, 1'b1, 1'b0, 1, 1'b0});
      vecs.push_back('{2'b11, 1'b1, 1'b0, 2, 1'b0});
      vecs.push_back('{2'b11, 1'b1, 1'b0, 2, 1'b0});
      vecs.push_back('{2'b11, 1'b1, 1'b0, 2, 1'b0});
      vecs.push_back('{2'b00, 1'b0, 1'b0, 0, 1'b0});
      vecs.push_back('{2'b11, 1'b0, 1'b0, 1, 1'b0});
      vecs.push_back('{2'b10, 1'b1, 1'b1, 0, 1'b0});
      foreach (vecs[i]) begin
         cyc_a(vecs[i].key, vecs[i].door, vecs[i].win);
         chk("vec alarm", alarm_a, int'(vecs[i].exp_alarm));
         if (ca_a) chk("vec state digit", an_a, int'(SEG[vecs[i].exp_st]));
         else if (vecs[i].exp_st != 2) chk("vec right digit", an_a, int'(SEG[0]));
      end

      // Alarm latches with sensors closed until disarmed.
      alarm_entry();
      repeat (5) begin
         cyc_a(2'b11, 1'b0, 1'b0);
         chk("alarm hold", alarm_a, 1);
      end
      cyc_a(2'b00, 1'b0, 1'b0);
      chk("alarm disarm", alarm_a, 0);

      // Disarm on the same edge the delay expires.
      cyc_a(2'b11, 1'b0, 1'b0);
      cyc_a(2'b11, 1'b0, 1'b1);
      repeat (49) cyc_a(2'b11, 1'b0, 1'b0);
      cyc_a(2'b00, 1'b0, 1'b0);
      chk("disarm priority alarm", alarm_a, 0);
      cyc_a(2'b11, 1'b0, 1'b0);
      chk("after priority alarm", alarm_a, 0);
      cyc_a(2'b00, 1'b0, 1'b0);

      // Async reset in ALARM, then a full-length delay again.
      alarm_entry();
      #2;
      rst = 1'b0;
      #1;
      chk("async rst alarm", alarm_a, 0);
      chk("async rst an", an_a, 7'b0111111);
      chk("async rst ca", ca_a, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      key_a = 2'b00;
      model_reset();
      alarm_entry();
      cyc_a(2'b00, 1'b0, 1'b0);

      // Random stimulus against the model.
      for (int i = 0; i < 800; i++) begin
         logic [1:0] k;
         k = ($urandom_range(0, 99) < 2) ? 2'($urandom_range(0, 2)) : 2'b11;
         cyc_a(k, $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0);
      end

      // CLK_FREQ=1000: CA toggles every cycle, right digit counts 5..1.
      do_reset();
      key_b = 2'b11;
      @(posedge clk); #1;
      door_b = 1'b1;
      @(posedge clk); #1;
      prev = int'(ca_b);
      for (int k = 0; k < 5000; k++) begin
         chk("B alarm low", alarm_b, 0);
         if (ca_b) chk("B left digit", an_b, 7'b1011011);
         else      chk("B right digit", an_b, int'(SEG[5 - k / 1000]));
         @(posedge clk); #1;
         chk("B ca toggle", ca_b, 1 - prev);
         prev = int'(ca_b);
      end
      chk("B alarm at 5000", alarm_b, 1);
      key_b = 2'b00; door_b = 1'b0;
      @(posedge clk); #1;
      chk("B disarm", alarm_b, 0);

      // CLK_FREQ=3000: refresh tick every third cycle.
      do_reset();
      prev = int'(ca_c); last = -1; first = -1; nt = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (int'(ca_c) != prev) begin
            if (last >= 0) chk("C tick period", i - last, 3);
            else first = i;
            last = i; prev = int'(ca_c); nt++;
         end
      end
      chk("C first toggle", first, 2);
      chk("C toggle count", nt, 10);
      chk("C alarm", alarm_c, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
